// File: rtl/scan_mux_sampler.sv
// N-channel W-bit registered multiplexer with manual select and auto scan.
// Each output sample is tagged with the channel index it was taken from.
module scan_mux_sampler #(
    parameter int NCH  = 4,
    parameter int W    = 1,
    parameter int SELW = $clog2(NCH),
    parameter int DWW  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [SELW-1:0]   sel_in,
    input  logic [DWW-1:0]    dwell,
    input  logic [NCH*W-1:0]  ch_in,
    output logic [W-1:0]      data_out,
    output logic [SELW-1:0]   ch_out,
    output logic              valid,
    output logic              wrap,
    output logic              sel_err
);

    localparam logic [SELW:0]   NCH_X = (SELW+1)'(NCH);
    localparam logic [SELW-1:0] LAST  = SELW'(NCH - 1);

    logic [W-1:0]    chans [NCH];

    logic [SELW-1:0] sel_q, sel_d;
    logic [DWW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]    data_q, data_d;
    logic [SELW-1:0] ch_q, ch_d;
    logic            valid_q, valid_d;
    logic            wrap_q, wrap_d;
    logic            err_q, err_d;

    logic            legal;
    logic            last;
    logic            adv;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            chans[k] = ch_in[k*W +: W];
        end
    end

    assign legal = {1'b0, sel_in} < NCH_X;
    assign last  = (sel_q == LAST);
    // >= rather than == so a lowered dwell takes effect on the next edge
    assign adv   = (cnt_q >= dwell);

    always_comb begin
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        err_d   = err_q;
        if (en) begin
            if (!mode) begin
                cnt_d = '0;
                if (legal) begin
                    data_d  = chans[sel_in];
                    ch_d    = sel_in;
                    sel_d   = sel_in;
                    valid_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                data_d  = chans[sel_q];
                ch_d    = sel_q;
                valid_d = 1'b1;
                if (adv) begin
                    cnt_d  = '0;
                    sel_d  = last ? '0 : sel_q + SELW'(1);
                    wrap_d = last;
                end else begin
                    cnt_d = cnt_q + DWW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign data_out = data_q;
    assign ch_out   = ch_q;
    assign valid    = valid_q;
    assign wrap     = wrap_q;
    assign sel_err  = err_q;

endmodule

// File: tb/tb_scan_mux_sampler.sv
// Bench for scan_mux_sampler: 4-channel and 5-channel instances, W=8.
// Vector table plus a queue of expected samples popped after each edge.
module tb_scan_mux_sampler;

    typedef struct {
        logic       rs;
        logic       d5;
        logic       en;
        logic       mode;
        logic [2:0] sel;
        logic [7:0] dw;
        logic [7:0] xd;
        logic [2:0] xc;
        logic       xv;
        logic       xw;
        logic       xe;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        en4 = 1'b0;
    logic        mode4 = 1'b0;
    logic [1:0]  sel4 = '0;
    logic [7:0]  dw4 = '0;
    logic [31:0] ch4 = 32'h44332211;
    logic [7:0]  do4;
    logic [1:0]  co4;
    logic        v4, w4, e4;

    logic        en5 = 1'b0;
    logic        mode5 = 1'b0;
    logic [2:0]  sel5 = '0;
    logic [7:0]  dw5 = '0;
    logic [39:0] ch5 = 40'h5544332211;
    logic [7:0]  do5;
    logic [2:0]  co5;
    logic        v5, w5, e5;

    int          n_vec = 0;
    int          n_bad = 0;
    vec_t        tbl[$];
    vec_t        sb[$];

    always #5 clk = ~clk;

    scan_mux_sampler #(.NCH(4), .W(8)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .mode(mode4),
        .sel_in(sel4), .dwell(dw4), .ch_in(ch4),
        .data_out(do4), .ch_out(co4), .valid(v4),
        .wrap(w4), .sel_err(e4)
    );

    scan_mux_sampler #(.NCH(5), .W(8)) dut5 (
        .clk(clk), .rst(rst), .en(en5), .mode(mode5),
        .sel_in(sel5), .dwell(dw5), .ch_in(ch5),
        .data_out(do5), .ch_out(co5), .valid(v5),
        .wrap(w5), .sel_err(e5)
    );

    function automatic vec_t mk(input logic rs, input logic d5,
                                input logic en, input logic mode,
                                input logic [2:0] sel,
                                input logic [7:0] dw,
                                input logic [7:0] xd,
                                input logic [2:0] xc,
                                input logic xv, input logic xw,
                                input logic xe);
        vec_t v;
        v.rs = rs; v.d5 = d5; v.en = en; v.mode = mode;
        v.sel = sel; v.dw = dw; v.xd = xd; v.xc = xc;
        v.xv = xv; v.xw = xw; v.xe = xe;
        return v;
    endfunction

    task automatic fld(input string tag, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL v%0d %s: got %0h want %0h", idx, tag, act, exp);
        end
    endtask

    task automatic cmp(input vec_t e, input int idx);
        n_vec++;
        if (e.d5) begin
            fld("d5.data", idx, do5, e.xd);
            fld("d5.ch", idx, {5'b0, co5}, {5'b0, e.xc});
            fld("d5.valid", idx, {7'b0, v5}, {7'b0, e.xv});
            fld("d5.wrap", idx, {7'b0, w5}, {7'b0, e.xw});
            fld("d5.err", idx, {7'b0, e5}, {7'b0, e.xe});
        end else begin
            fld("d4.data", idx, do4, e.xd);
            fld("d4.ch", idx, {6'b0, co4}, {5'b0, e.xc});
            fld("d4.valid", idx, {7'b0, v4}, {7'b0, e.xv});
            fld("d4.wrap", idx, {7'b0, w4}, {7'b0, e.xw});
            fld("d4.err", idx, {7'b0, e4}, {7'b0, e.xe});
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        if (v.d5) begin
            en4 = 1'b0;
            en5 = v.en; mode5 = v.mode; sel5 = v.sel; dw5 = v.dw;
        end else begin
            en5 = 1'b0;
            en4 = v.en; mode4 = v.mode; sel4 = v.sel[1:0]; dw4 = v.dw;
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        vec_t e;
        drive(v);
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL v%0d scoreboard: got empty want entry", idx);
        end else begin
            e = sb.pop_front();
            cmp(e, idx);
        end
    endtask

    initial begin
        vec_t z;
        logic [2:0] c;

        // manual sweep
        tbl.push_back(mk(1,0,1,0,0,0, 8'h11,0,1,0,0));
        tbl.push_back(mk(0,0,1,0,1,0, 8'h22,1,1,0,0));
        tbl.push_back(mk(0,0,1,0,2,0, 8'h33,2,1,0,0));
        tbl.push_back(mk(0,0,1,0,3,0, 8'h44,3,1,0,0));
        // scan, dwell 0, ten edges after reset
        for (int i = 0; i < 10; i++) begin
            c = 3'(i % 4);
            tbl.push_back(mk(i == 0, 0, 1, 1, 0, 0,
                             8'h11 * (8'(c) + 8'd1), c,
                             1, c == 3'd3, 0));
        end
        // scan, dwell 2, then dwell dropped to 0 at cnt 1
        tbl.push_back(mk(1,0,1,1,0,2, 8'h11,0,1,0,0));
        tbl.push_back(mk(0,0,1,1,0,2, 8'h11,0,1,0,0));
        tbl.push_back(mk(0,0,1,1,0,2, 8'h11,0,1,0,0));
        tbl.push_back(mk(0,0,1,1,0,2, 8'h22,1,1,0,0));
        tbl.push_back(mk(0,0,1,1,0,0, 8'h22,1,1,0,0));
        tbl.push_back(mk(0,0,1,1,0,0, 8'h33,2,1,0,0));
        tbl.push_back(mk(0,0,1,1,0,0, 8'h44,3,1,1,0));
        // 5-channel illegal select, sticky error, en freeze
        tbl.push_back(mk(0,1,1,0,2,0, 8'h33,2,1,0,0));
        tbl.push_back(mk(0,1,1,0,4,0, 8'h55,4,1,0,0));
        tbl.push_back(mk(0,1,1,0,5,0, 8'h55,4,0,0,1));
        tbl.push_back(mk(0,1,1,0,6,0, 8'h55,4,0,0,1));
        tbl.push_back(mk(0,1,1,0,1,0, 8'h22,1,1,0,1));
        tbl.push_back(mk(0,1,0,0,3,0, 8'h22,1,0,0,1));
        tbl.push_back(mk(0,1,0,1,0,0, 8'h22,1,0,0,1));
        tbl.push_back(mk(0,1,0,0,0,0, 8'h22,1,0,0,1));
        // manual 2 -> scan dwell 1 -> manual
        tbl.push_back(mk(1,0,1,0,2,1, 8'h33,2,1,0,0));
        tbl.push_back(mk(0,0,1,1,0,1, 8'h33,2,1,0,0));
        tbl.push_back(mk(0,0,1,1,0,1, 8'h33,2,1,0,0));
        tbl.push_back(mk(0,0,1,1,0,1, 8'h44,3,1,0,0));
        tbl.push_back(mk(0,0,1,1,0,1, 8'h44,3,1,1,0));
        tbl.push_back(mk(0,0,1,1,0,1, 8'h11,0,1,0,0));
        tbl.push_back(mk(0,0,1,0,1,1, 8'h22,1,1,0,0));
        tbl.push_back(mk(0,0,0,1,0,0, 8'h22,1,0,0,0));

        z = mk(0,0,0,0,0,0, 8'h00,0,0,0,0);
        @(posedge clk);
        #1;
        cmp(z, -1);
        z.d5 = 1'b1;
        cmp(z, -2);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rs) pulse_rst();
            step(tbl[i], i);
        end

        // asynchronous reset mid-scan while ch 2 is on the output
        pulse_rst();
        for (int i = 0; i < 3; i++) begin
            step(mk(0,0,1,1,0,0, 8'h11 * 8'(i + 1), 3'(i), 1,0,0), 100 + i);
        end
        #3;
        rst = 1'b1;
        #1;
        z = mk(0,0,0,0,0,0, 8'h00,0,0,0,0);
        cmp(z, 200);
        @(negedge clk);
        rst = 1'b0;
        step(mk(0,0,1,1,0,0, 8'h11,0,1,0,0), 201);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
